// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, state type and small helpers
// for the four-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    DEAD,
    DRIVE
  } scan_state_t;

  // Nibble of a packed 16-bit value for digit k.
  function automatic logic [3:0] nibble_of(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    logic [3:0] n;
    n = v[3:0];
    unique case (k)
      2'd0: n = v[3:0];
      2'd1: n = v[7:4];
      2'd2: n = v[11:8];
      2'd3: n = v[15:12];
    endcase
    return n;
  endfunction

  // Active-low anode pattern enabling only digit k.
  function automatic logic [3:0] anode_sel(
    input logic [1:0] k
  );
    logic [3:0] a;
    a = AN_OFF;
    a[k] = 1'b0;
    return a;
  endfunction

  // A digit is blank when it and every more
  // significant digit are zero and its dp is off.
  // Digit 0 always shows.
  function automatic logic blank_digit(
    input logic [15:0] v,
    input logic [3:0]  d,
    input logic [1:0]  k
  );
    logic b;
    b = 1'b0;
    unique case (k)
      2'd0: b = 1'b0;
      2'd1: b = (v[15:4] == 12'h000) && !d[1];
      2'd2: b = (v[15:8] == 8'h00) && !d[2];
      2'd3: b = (v[15:12] == 4'h0) && !d[3];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_to_bcd.sv
// Hex nibble to active-low seven-segment glyph.
// Output bit 6 is segment a, bit 0 is segment g.
module hex_to_bcd (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup, segments a..g from MSB to LSB
  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with a
// double-buffered value register committed only at
// frame end. Define SEG_SCAN_LEADING_ZERO_BLANK_EN
// to blank leading zero digits.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_END =
    CW'(DEAD_CYC);

  scan_state_t   state_q;
  scan_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [15:0]   disp_q;
  logic [15:0]   disp_d;
  logic [3:0]    ddp_q;
  logic [3:0]    ddp_d;
  logic [15:0]   pend_q;
  logic [3:0]    pdp_q;
  logic          pv_q;
  logic          wrap;
  logic          frame_end;
  logic          commit;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic          ft_d;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          ft_q;

  assign wrap      = (cnt_q == LAST);
  assign frame_end = wrap && (idx_q == 2'd3);
  assign commit    = frame_end && pv_q;

  // Next slot position and the value shown from
  // the next cycle on (display only moves at frame end)
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    disp_d = disp_q;
    ddp_d  = ddp_q;
    if (wrap) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    if (commit) begin
      disp_d = pend_q;
      ddp_d  = pdp_q;
    end
  end

  assign nib = nibble_of(disp_d, idx_d);

  hex_to_bcd u_glyph (
    .hex (nib),
    .seg (glyph)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign blank = blank_digit(disp_d, ddp_d, idx_d);
`else
  assign blank = 1'b0;
`endif

  // Next FSM state and the registered output values
  // for the count being entered on this edge
  always_comb begin
    state_d = state_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    ft_d    = (cnt_d == LAST) && (idx_d == 2'd3);
    unique case (state_q)
      DEAD: begin
        if (cnt_d == DEAD_END) state_d = DRIVE;
      end
      DRIVE: begin
        if (wrap) state_d = DEAD;
      end
    endcase
    if ((state_d == DRIVE) && !blank) begin
      an_d  = anode_sel(idx_d);
      seg_d = glyph;
      dp_d  = ~ddp_d[idx_d];
    end
  end

  // Scan position, FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ft_q    <= ft_d;
    end
  end

  // Display and pending buffers; a load seen on the
  // frame-end cycle lands in pending for next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= 16'h0000;
      ddp_q  <= 4'h0;
      pend_q <= 16'h0000;
      pdp_q  <= 4'h0;
      pv_q   <= 1'b0;
    end else begin
      disp_q <= disp_d;
      ddp_q  <= ddp_d;
      if (commit) begin
        pv_q <= 1'b0;
      end else if (load && !pv_q) begin
        pend_q <= value_in;
        pdp_q  <= dp_in;
        pv_q   <= 1'b1;
      end
    end
  end

  assign ready      = ~pv_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-time
// reference model predicts every output cycle.
module tb_seg_scan_ctrl;

  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg_scan_ctrl #(
    .REFRESH_DIV (DIV),
    .DEAD_CYC    (DEAD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .ready      (ready),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } obs_t;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  obs_t        exp_q [$];
  int          t_q   [$];
  int          checks = 0;
  int          passed = 0;

  int          t;
  logic [15:0] m_disp;
  logic [3:0]  m_ddp;
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;
  logic        m_pv;

  function automatic int pos_of(input int tt);
    return tt % DIV;
  endfunction

  function automatic int idx_of(input int tt);
    return (tt / DIV) % 4;
  endfunction

  function automatic bit is_fe(input int tt);
    return pos_of(tt) == DIV - 1 && idx_of(tt) == 3;
  endfunction

  function automatic bit m_blank(input int k);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    return ((m_disp >> (4 * k)) == 16'h0) && !m_ddp[k];
`else
    return 1'b0;
`endif
  endfunction

  function automatic obs_t predict();
    obs_t o;
    int   k;
    logic [15:0] sh;
    k     = idx_of(t);
    o.rdy = !m_pv;
    o.ft  = is_fe(t);
    o.an  = 4'b1111;
    o.seg = 7'b1111111;
    o.dp  = 1'b1;
    if (pos_of(t) >= DEAD && !m_blank(k)) begin
      sh    = m_disp >> (4 * k);
      o.an  = 4'b1111 & ~(4'b0001 << k);
      o.seg = glyph[sh[3:0]];
      o.dp  = ~m_ddp[k];
    end
    return o;
  endfunction

  task automatic model_step(
    input bit r, input bit l,
    input logic [15:0] v, input logic [3:0] d
  );
    if (r) begin
      t      = 0;
      m_disp = 16'h0;
      m_ddp  = 4'h0;
      m_pend = 16'h0;
      m_pdp  = 4'h0;
      m_pv   = 1'b0;
    end else begin
      if (is_fe(t) && m_pv) begin
        m_disp = m_pend;
        m_ddp  = m_pdp;
        m_pv   = 1'b0;
      end else if (l && !m_pv) begin
        m_pend = v;
        m_pdp  = d;
        m_pv   = 1'b1;
      end
      t++;
    end
  endtask

  task automatic cyc(
    input bit r, input bit l,
    input logic [15:0] v, input logic [3:0] d
  );
    reset    = r;
    load     = l;
    value_in = v;
    dp_in    = d;
    @(posedge clk);
    #1;
    model_step(r, l, v, d);
    exp_q.push_back(predict());
    t_q.push_back(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Monitor: compare DUT outputs mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      int   tt;
      e  = exp_q.pop_front();
      tt = t_q.pop_front();
      a  = {ready, an, seg, dp, frame_tick};
      checks++;
      if (a === e) passed++;
      else
        $display(
          "FAIL scan t=%0d got rdy=%b an=%b seg=%b dp=%b ft=%b want rdy=%b an=%b seg=%b dp=%b ft=%b",
          tt, a.rdy, a.an, a.seg, a.dp, a.ft,
          e.rdy, e.an, e.seg, e.dp, e.ft);
    end
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0;
    dp_in    = 4'h0;
    t        = 0;
    m_disp   = 16'h0;
    m_ddp    = 4'h0;
    m_pend   = 16'h0;
    m_pdp    = 4'h0;
    m_pv     = 1'b0;

    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    cyc(1'b1, 1'b1, 16'hBEEF, 4'hF);
    cyc(1'b0, 1'b0, 16'h0, 4'h0);
    idle(31);

    idle(5);
    cyc(1'b0, 1'b1, 16'h1A3F, 4'b0100);
    idle(4 * DIV * 2);

    for (int i = 0; i < 100 && m_pv; i++) idle(1);
    cyc(1'b0, 1'b1, 16'h0000, 4'h0);
    cyc(1'b0, 1'b1, 16'hFFFF, 4'hF);
    idle(4 * DIV * 2);

    for (int i = 0; i < 200 && !(is_fe(t) && !m_pv); i++)
      idle(1);
    cyc(1'b0, 1'b1, 16'h4444, 4'h0);
    idle(4 * DIV * 3);

    for (int i = 0; i < 100 && m_pv; i++) idle(1);
    cyc(1'b0, 1'b1, 16'h1234, 4'h3);
    for (int i = 0; i < 200 &&
         !(idx_of(t) == 2 && pos_of(t) == 5); i++)
      idle(1);
    cyc(1'b1, 1'b1, 16'h5678, 4'hF);
    idle(4 * DIV * 2);

    cyc(1'b0, 1'b1, 16'h0070, 4'h0);
    idle(4 * DIV * 2);
    cyc(1'b0, 1'b1, 16'h0100, 4'h2);
    idle(4 * DIV * 2);

    for (int i = 0; i < 2000; i++) begin
      bit          r;
      bit          l;
      logic [15:0] v;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 0) v = v >> 4 * $urandom_range(0, 3);
      cyc(r, l, v, 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain got %0d left want 0",
               exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot.
REQ-002 Parameter DEAD_CYC, default 4: all-anodes-off cycles at the start of each slot; DEAD_CYC < REFRESH_DIV SHALL hold.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load  in  1  request to accept value_in/dp_in.
REQ-006 value_in  in  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-007 dp_in  in  4  per-digit decimal point, 1 = lit; bit k is digit k.
REQ-008 ready  out  1  high when a load SHALL be accepted.
REQ-009 an  out  4  active-low anode enables; bit k is digit k.
REQ-010 seg  out  7  active-low segments, bit order [0:6] = a..g.
REQ-011 dp  out  1  active-low decimal point.
REQ-012 frame_tick  out  1  one-cycle pulse at the end of digit 3's slot.

Function
REQ-013 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-014 FSM states: DEAD when count < DEAD_CYC, DRIVE otherwise. DEAD->DRIVE at count = DEAD_CYC. DRIVE->DEAD on slot wrap.
REQ-015 In DEAD, an SHALL be 4'b1111. In DRIVE, only an[idx] SHALL be 0.
REQ-016 In DRIVE, seg SHALL be the hex glyph of the displayed nibble for idx. In DRIVE, dp SHALL be ~dp bit idx.
REQ-017 In DEAD, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-018 an, seg and dp SHALL be registered. They SHALL change on the same edge that moves the counter into the new count.
REQ-019 Double buffering: load && ready SHALL capture value_in/dp_in into a pending register. On the next edge, ready SHALL go 0.
REQ-020 load while ready = 0 SHALL be ignored; pending SHALL be unchanged.
REQ-021 On the cycle digit 3's slot wraps, frame_tick SHALL be 1. On that edge, if pending is valid, the display register SHALL take the pending register and ready SHALL return to 1.
REQ-022 If a load is accepted on the frame-end cycle itself, it SHALL NOT commit that frame. It SHALL commit at the following frame end.
REQ-023 The displayed value SHALL never change mid-frame (no tearing).

Reset
REQ-024 While reset = 1 on an edge, the following SHALL be cleared: counter = 0, idx = 0, display = 16'h0000, display dp = 0, pending invalid. Outputs SHALL be: ready = 1, an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
REQ-025 Reset asserted mid-slot or with a load pending SHALL discard pending data. After reset deasserts, scanning SHALL restart at digit 0, count 0 (DEAD).
REQ-026 reset SHALL take priority over a simultaneous load.

Configuration
REQ-027 Macro SEG_SCAN_LEADING_ZERO_BLANK_EN. When defined, a digit SHALL be blanked if it and all more-significant digits are 0 and its dp bit is 0. Blanked means an[idx] stays 1 for the whole slot. Digit 0 SHALL never be blanked. When undefined, all four digits SHALL always be driven.

Structure
REQ-028 The shared package SHALL hold: NUM_DIGITS = 4, SEG_OFF = 7'b1111111, AN_OFF = 4'b1111, and the state enum {DEAD, DRIVE}.
REQ-029 Glyph decode SHALL instantiate the existing hex_to_bcd 7-segment decoder as the only sub-module; it SHALL NOT be re-implemented.

Verification (REFRESH_DIV = 8, DEAD_CYC = 2)
REQ-030 Reset, then idle 32 cycles. Required: ready = 1; an sequence per slot is 1111 x2, then 1110/1101/1011/0111 x6; seg = 0000001 while driving; frame_tick high at cycle 31 only.
REQ-031 Load 16'h1A3F with dp_in = 4'b0100 at cycle 5. Required: ready = 0 from cycle 6 until frame end (cycle 31). From cycle 32, seg per digit is 0111000, 0000110, 0001000, 1001111; dp = 0 only during digit 2.
REQ-032 Load 16'h0000, then load 16'hFFFF while ready = 0. Required: the second load is ignored; 0000 is displayed next frame.
REQ-033 Load 16'h4444 on the frame-end cycle. Required: old value is shown one more full frame; 4444 appears after the second frame_tick.
REQ-034 Assert reset at slot count 5 of digit 2 with a load pending. Required: next cycle an = 1111, ready = 1, display = 0; scanning resumes at digit 0.
REQ-035 With SEG_SCAN_LEADING_ZERO_BLANK_EN, load 16'h0070. Required: an[3] and an[2] stay 1 all frame; digits 1 and 0 are driven with 0001111 and 0000001.
